// File: rtl/mem_model_axi_lat_pkg.sv
// Shared constants and helpers for the burst memory model: FSM encodings
// and the beat-size arithmetic used by both channel engines.
package mem_model_axi_lat_pkg;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_DELAY = 2'd1;
  localparam logic [1:0] R_FETCH = 2'd2;
  localparam logic [1:0] R_DATA  = 2'd3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DELAY = 2'd1;
  localparam logic [1:0] W_DATA  = 2'd2;
  localparam logic [1:0] W_RESP  = 2'd3;

  function automatic int byte_shift(input int dwidth);
    return $clog2(dwidth / 8);
  endfunction

  // Beats wider than the data bus are treated as full-width beats.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/mem_model_axi_lat_sync_ram_dp_be.sv
// Dual-port synchronous RAM: port 0 registered read (holds when disabled),
// port 1 byte-masked write. A same-address read and write returns old data.
module sync_ram_dp_be #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en0,
  input  logic [AWIDTH-1:0]     addr0,
  output logic [DWIDTH-1:0]     rdata0,
  input  logic                  en1,
  input  logic [DWIDTH/8-1:0]   we1,
  input  logic [AWIDTH-1:0]     addr1,
  input  logic [DWIDTH-1:0]     wdata1
);
  localparam int NB    = DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (en1 && we1[gi]) begin
          mem[addr1] <= wdata1[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (en0) begin
          rd_lane_reg <= mem[addr0];
        end
      end

      assign rdata0[gi*8 +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_model_axi_lat.sv
// Burst request memory model with independent, delay-configurable read and
// write engines in front of a dual-port byte-enabled RAM.
module mem_model_axi_lat
  import mem_model_axi_lat_pkg::*;
#(
  parameter int AXI_AWIDTH  = 32,
  parameter int AXI_DWIDTH  = 32,
  parameter int MEM_AWIDTH  = 14,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_request_valid,
  output logic                    read_request_ready,
  input  logic [AXI_AWIDTH-1:0]   read_request_addr,
  input  logic [31:0]             read_len,
  input  logic [2:0]              read_size,
  output logic [AXI_DWIDTH-1:0]   read_data,
  output logic                    read_data_valid,
  input  logic                    read_data_ready,
  output logic                    read_data_last,
  input  logic                    write_request_valid,
  output logic                    write_request_ready,
  input  logic [AXI_AWIDTH-1:0]   write_request_addr,
  input  logic [31:0]             write_len,
  input  logic [2:0]              write_size,
  input  logic [AXI_DWIDTH-1:0]   write_data,
  input  logic [AXI_DWIDTH/8-1:0] write_strb,
  input  logic                    write_data_valid,
  output logic                    write_data_ready,
  output logic                    write_resp_valid,
  input  logic                    write_resp_ready
);
  localparam int         BYTE_SHIFT = byte_shift(AXI_DWIDTH);
  localparam logic [2:0] MAX_SIZE   = 3'(BYTE_SHIFT);

  // Holds both request-ready outputs low until the first edge after reset.
  logic init_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_reg <= 1'b0;
    else     init_reg <= 1'b1;
  end

  // ---------------- read engine ----------------
  logic [1:0]            rd_state_reg, rd_state_next;
  logic [7:0]            rd_delay_reg;
  logic [31:0]           rd_cnt_reg, rd_len_reg, rd_fetch_idx;
  logic [AXI_AWIDTH-1:0] rd_addr_reg, rd_byte_addr;
  logic [2:0]            rd_size_reg;
  logic [MEM_AWIDTH-1:0] rd_word_addr;
  logic                  rd_req_fire, rd_data_fire, rd_last, rd_ram_en;

  assign read_request_ready = init_reg && (rd_state_reg == R_IDLE);
  assign read_data_valid    = (rd_state_reg == R_DATA);
  assign rd_req_fire        = read_request_valid && read_request_ready;
  assign rd_data_fire       = read_data_valid && read_data_ready;
  assign rd_last            = (rd_cnt_reg == rd_len_reg);
  assign read_data_last     = read_data_valid && rd_last;

  // Prefetch the next beat on every non-last fire so bursts stream at full rate.
  assign rd_ram_en    = (rd_state_reg == R_FETCH) || (rd_data_fire && !rd_last);
  assign rd_fetch_idx = (rd_state_reg == R_FETCH) ? 32'd0 : rd_cnt_reg + 32'd1;
  assign rd_byte_addr = rd_addr_reg + AXI_AWIDTH'({32'd0, rd_fetch_idx} << rd_size_reg);
  assign rd_word_addr = MEM_AWIDTH'(rd_byte_addr >> BYTE_SHIFT);

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (rd_req_fire) rd_state_next = (READ_DELAY > 0) ? R_DELAY : R_FETCH;
      R_DELAY: if (rd_delay_reg == 8'(READ_DELAY - 1)) rd_state_next = R_FETCH;
      R_FETCH: rd_state_next = R_DATA;
      R_DATA:  if (rd_data_fire && rd_last) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      rd_delay_reg <= '0;
      rd_cnt_reg   <= '0;
      rd_len_reg   <= '0;
      rd_addr_reg  <= '0;
      rd_size_reg  <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_delay_reg <= (rd_state_reg == R_DELAY) ? rd_delay_reg + 8'd1 : 8'd0;
      if (rd_req_fire) begin
        rd_addr_reg <= read_request_addr;
        rd_len_reg  <= read_len;
        rd_size_reg <= clamp_size(read_size, MAX_SIZE);
        rd_cnt_reg  <= '0;
      end else if (rd_data_fire && !rd_last) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      end
    end
  end

  // ---------------- write engine ----------------
  logic [1:0]            wr_state_reg, wr_state_next;
  logic [7:0]            wr_delay_reg;
  logic [31:0]           wr_cnt_reg, wr_len_reg;
  logic [AXI_AWIDTH-1:0] wr_addr_reg, wr_byte_addr;
  logic [2:0]            wr_size_reg;
  logic [MEM_AWIDTH-1:0] wr_word_addr;
  logic                  wr_req_fire, wr_data_fire, wr_last;

  assign write_request_ready = init_reg && (wr_state_reg == W_IDLE);
  assign write_data_ready    = (wr_state_reg == W_DATA);
  assign write_resp_valid    = (wr_state_reg == W_RESP);
  assign wr_req_fire         = write_request_valid && write_request_ready;
  assign wr_data_fire        = write_data_valid && write_data_ready;
  assign wr_last             = (wr_cnt_reg == wr_len_reg);
  assign wr_byte_addr        = wr_addr_reg + AXI_AWIDTH'({32'd0, wr_cnt_reg} << wr_size_reg);
  assign wr_word_addr        = MEM_AWIDTH'(wr_byte_addr >> BYTE_SHIFT);

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:  if (wr_req_fire) wr_state_next = (WRITE_DELAY > 0) ? W_DELAY : W_DATA;
      W_DELAY: if (wr_delay_reg == 8'(WRITE_DELAY - 1)) wr_state_next = W_DATA;
      W_DATA:  if (wr_data_fire && wr_last) wr_state_next = W_RESP;
      W_RESP:  if (write_resp_ready) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      wr_delay_reg <= '0;
      wr_cnt_reg   <= '0;
      wr_len_reg   <= '0;
      wr_addr_reg  <= '0;
      wr_size_reg  <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_delay_reg <= (wr_state_reg == W_DELAY) ? wr_delay_reg + 8'd1 : 8'd0;
      if (wr_req_fire) begin
        wr_addr_reg <= write_request_addr;
        wr_len_reg  <= write_len;
        wr_size_reg <= clamp_size(write_size, MAX_SIZE);
        wr_cnt_reg  <= '0;
      end else if (wr_data_fire && !wr_last) begin
        wr_cnt_reg <= wr_cnt_reg + 32'd1;
      end
    end
  end

  sync_ram_dp_be #(
    .DWIDTH (AXI_DWIDTH),
    .AWIDTH (MEM_AWIDTH)
  ) u_ram (
    .clk    (clk),
    .en0    (rd_ram_en),
    .addr0  (rd_word_addr),
    .rdata0 (read_data),
    .en1    (wr_data_fire),
    .we1    (write_strb),
    .addr1  (wr_word_addr),
    .wdata1 (write_data)
  );

endmodule

// File: tb/tb_mem_model_axi_lat.sv
// Directed bench for mem_model_axi_lat with a 16-word RAM, READ_DELAY=2, WRITE_DELAY=0.
module tb_mem_model_axi_lat;
  logic        clk = 1'b0;
  logic        rst;
  logic        read_request_valid, read_request_ready;
  logic [31:0] read_request_addr, read_len;
  logic [2:0]  read_size;
  logic [31:0] read_data;
  logic        read_data_valid, read_data_ready, read_data_last;
  logic        write_request_valid, write_request_ready;
  logic [31:0] write_request_addr, write_len;
  logic [2:0]  write_size;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        write_data_valid, write_data_ready;
  logic        write_resp_valid, write_resp_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  always #5 clk = ~clk;

  mem_model_axi_lat #(
    .AXI_AWIDTH(32), .AXI_DWIDTH(32), .MEM_AWIDTH(4), .READ_DELAY(2), .WRITE_DELAY(0)
  ) dut (
    .clk(clk), .rst(rst),
    .read_request_valid(read_request_valid), .read_request_ready(read_request_ready),
    .read_request_addr(read_request_addr), .read_len(read_len), .read_size(read_size),
    .read_data(read_data), .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
    .read_data_last(read_data_last),
    .write_request_valid(write_request_valid), .write_request_ready(write_request_ready),
    .write_request_addr(write_request_addr), .write_len(write_len), .write_size(write_size),
    .write_data(write_data), .write_strb(write_strb),
    .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the response handshake.
  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [3:0] strb);
    write_request_valid = 1'b1;
    write_request_addr  = addr;
    write_len           = len;
    write_size          = 3'd2;
    chk("wr_req_ready", write_request_ready, 1);
    @(negedge clk);
    write_request_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      chk("wr_data_ready", write_data_ready, 1);
      chk("wr_resp_early", write_resp_valid, 0);
      write_data_valid = 1'b1;
      write_data       = wbuf[i];
      write_strb       = strb;
      @(negedge clk);
    end
    write_data_valid = 1'b0;
    chk("wr_resp_valid", write_resp_valid, 1);
    write_resp_ready = 1'b1;
    @(negedge clk);
    write_resp_ready = 1'b0;
    chk("wr_resp_drop", write_resp_valid, 0);
    chk("wr_req_ready_after", write_request_ready, 1);
  endtask

  // bp toggles read_data_ready every cycle; stalled beats must hold their data.
  task automatic rd_burst(input logic [31:0] addr, input int len, input bit bp);
    int          beat;
    int          cyc;
    bit          stalled;
    logic [31:0] held;
    read_request_valid = 1'b1;
    read_request_addr  = addr;
    read_len           = len;
    read_size          = 3'd2;
    read_data_ready    = 1'b1;
    chk("rd_req_ready", read_request_ready, 1);
    @(negedge clk);
    read_request_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rd_lat_idle", read_data_valid, 0);
      @(negedge clk);
    end
    chk("rd_first_valid", read_data_valid, 1);
    beat = 0; cyc = 0; stalled = 0; held = '0;
    while (beat <= len && cyc < 64) begin
      if (stalled) chk("rd_hold", read_data, held);
      read_data_ready = bp ? (cyc % 2 == 0) : 1'b1;
      if (read_data_valid && read_data_ready) begin
        chk("rd_data", read_data, ebuf[beat]);
        chk("rd_last", read_data_last, (beat == len) ? 32'd1 : 32'd0);
        beat++;
        stalled = 0;
      end else begin
        stalled = read_data_valid;
        held    = read_data;
      end
      @(negedge clk);
      cyc++;
    end
    if (beat <= len) chk("rd_timeout_beats", beat, len + 1);
    read_data_ready = 1'b0;
    chk("rd_valid_drop", read_data_valid, 0);
    chk("rd_req_ready_after", read_request_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    read_request_valid = 0; read_request_addr = 0; read_len = 0; read_size = 0; read_data_ready = 0;
    write_request_valid = 0; write_request_addr = 0; write_len = 0; write_size = 0;
    write_data = 0; write_strb = 0; write_data_valid = 0; write_resp_ready = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_rd_valid", read_data_valid, 0);
    chk("rst_rd_last", read_data_last, 0);
    chk("rst_wr_resp", write_resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_req_ready", read_request_ready, 1);
    chk("rst_wr_req_ready", write_request_ready, 1);

    // Write then read 0x100, 4 beats (words 0..3)
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; ebuf[i] = 32'hA0 + i; end
    wr_burst(32'h100, 3, 4'hF);
    rd_burst(32'h100, 3, 1'b0);

    // Byte strobes on word 4
    wbuf[0] = 32'h11223344;
    wr_burst(32'h10, 0, 4'hF);
    wbuf[0] = 32'hAABBCCDD;
    wr_burst(32'h10, 0, 4'b0101);
    ebuf[0] = 32'h11BB33DD;
    rd_burst(32'h10, 0, 1'b0);

    // 8-beat read under backpressure (words 8..15)
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hB0 + i; ebuf[i] = 32'hB0 + i; end
    wr_burst(32'h20, 7, 4'hF);
    rd_burst(32'h20, 7, 1'b1);

    // Address wrap: word 15 then word 0
    wbuf[0] = 32'hC1; wbuf[1] = 32'hC2;
    wr_burst(32'h3C, 1, 4'hF);
    ebuf[0] = 32'hC2;
    rd_burst(32'h00, 0, 1'b0);
    ebuf[0] = 32'hC1; ebuf[1] = 32'hC2;
    rd_burst(32'h3C, 1, 1'b0);

    // Concurrent write (words 1..2) and read (words 8..11)
    wbuf[0] = 32'hD1; wbuf[1] = 32'hD2;
    for (int i = 0; i < 4; i++) ebuf[i] = 32'hB0 + i;
    fork
      wr_burst(32'h04, 1, 4'hF);
      rd_burst(32'h20, 3, 1'b0);
    join
    ebuf[0] = 32'hC2; ebuf[1] = 32'hD1; ebuf[2] = 32'hD2;
    rd_burst(32'h00, 2, 1'b0);

    // Same-cycle read fetch and write of word 5: read sees the old value
    wbuf[0] = 32'h55;
    wr_burst(32'h14, 0, 4'hF);
    read_request_valid = 1'b1; read_request_addr = 32'h14; read_len = 0; read_size = 3'd2;
    read_data_ready = 1'b1;
    @(negedge clk);
    read_request_valid = 1'b0;
    @(negedge clk);
    write_request_valid = 1'b1; write_request_addr = 32'h14; write_len = 0; write_size = 3'd2;
    @(negedge clk);
    write_request_valid = 1'b0;
    chk("col_wr_ready", write_data_ready, 1);
    write_data_valid = 1'b1; write_data = 32'h66; write_strb = 4'hF;
    @(negedge clk);
    write_data_valid = 1'b0;
    chk("col_rd_valid", read_data_valid, 1);
    chk("col_rd_old_data", read_data, 32'h55);
    chk("col_rd_last", read_data_last, 1);
    chk("col_wr_resp", write_resp_valid, 1);
    write_resp_ready = 1'b1;
    @(negedge clk);
    write_resp_ready = 1'b0;
    read_data_ready  = 1'b0;
    chk("col_rd_done", read_data_valid, 0);
    ebuf[0] = 32'h66;
    rd_burst(32'h14, 0, 1'b0);

    // Reset during beat 2 of a 4-beat read
    read_request_valid = 1'b1; read_request_addr = 32'h20; read_len = 3; read_size = 3'd2;
    read_data_ready = 1'b1;
    @(negedge clk);
    read_request_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_beat2_data", read_data, 32'hB2);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid", read_data_valid, 0);
    chk("mid_rst_rd_last", read_data_last, 0);
    chk("mid_rst_wr_resp", write_resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    read_data_ready = 1'b0;
    @(negedge clk);
    chk("mid_rd_req_ready", read_request_ready, 1);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'hB0 + i;
    rd_burst(32'h20, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
